pit_prescale_ctrl: RTL and testbench

Controls one PIT prescale counter. It drives the counter's enable (cnt_sync_o) and its 4-bit divisor select, and observes the counter's prescale_out tick. Divisor changes are held in a shadow register and applied only at tick boundaries or while stopped, so the counter never sees a mid-count divisor change. It also provides a graceful-stop option and a burst (N-tick one-shot) mode.

---
 rtl/pit_prescale_ctrl_if.sv | 28 ++
 rtl/pit_prescale_ctrl.sv | 114 +++++++++++
 tb/tb_pit_prescale_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pit_prescale_ctrl_if.sv
// Host/counter-side signal bundle for one PIT prescale controller.
// master drives the run/divisor requests and the counter tick; slave is the controller.
interface pit_prescale_ctrl_if #(
    parameter int BURST_SIZE = 16
);
    logic                  pit_en;
    logic                  grace_stop;
    logic                  div_wr;
    logic [3:0]            div_wdata;
    logic [BURST_SIZE-1:0] burst_len;
    logic                  prescale_out;
    logic                  cnt_sync_o;
    logic [3:0]            divisor_o;
    logic                  div_pending;
    logic                  busy;
    logic                  burst_done;
    logic [BURST_SIZE-1:0] ticks_left;

    modport master (
        output pit_en, grace_stop, div_wr, div_wdata, burst_len, prescale_out,
        input  cnt_sync_o, divisor_o, div_pending, busy, burst_done, ticks_left
    );

    modport slave (
        input  pit_en, grace_stop, div_wr, div_wdata, burst_len, prescale_out,
        output cnt_sync_o, divisor_o, div_pending, busy, burst_done, ticks_left
    );
endinterface

// File: rtl/pit_prescale_ctrl.sv
// PIT prescale counter controller: run/stop/burst sequencing with tick-aligned divisor updates.
// Latency: every output registered, 1 cycle from inputs; no backpressure (level/strobe inputs).
// Divisor writes while running park in a shadow register until the next tick or return to idle.
module pit_prescale_ctrl #(
    parameter int DECADE_CNTR = 1,
    parameter int BURST_SIZE  = 16
) (
    input  logic               bus_clk,
    input  logic               async_rst_b,
    input  logic               sync_reset,
    pit_prescale_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

    state_t                state_q;
    logic                  cnt_sync_q;
    logic [3:0]            divisor_q;
    logic [3:0]            shadow_q;
    logic                  div_pending_q;
    logic                  busy_q;
    logic                  burst_done_q;
    logic [BURST_SIZE-1:0] ticks_left_q;
    logic                  done_lock_q;

    logic [3:0] wv;
    logic       tick;
    logic       burst_end;
    logic       to_idle;

    assign wv        = (DECADE_CNTR != 0 && bus.div_wdata > 4'd8) ? 4'd8 : bus.div_wdata;
    assign tick      = bus.prescale_out & cnt_sync_q;
    assign burst_end = tick && (ticks_left_q == BURST_SIZE'(1));
    // Burst completion outranks a falling pit_en; a returning pit_en outranks a graceful-stop tick.
    assign to_idle   = burst_end
                     || (state_q == ST_RUN  && !bus.pit_en && !bus.grace_stop)
                     || (state_q == ST_STOP && !bus.pit_en && tick);

    always_ff @(posedge bus_clk or negedge async_rst_b) begin
        if (!async_rst_b) begin
            state_q       <= ST_IDLE;
            cnt_sync_q    <= 1'b0;
            divisor_q     <= 4'd0;
            shadow_q      <= 4'd0;
            div_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            burst_done_q  <= 1'b0;
            ticks_left_q  <= '0;
            done_lock_q   <= 1'b0;
        end else if (sync_reset) begin
            state_q       <= ST_IDLE;
            cnt_sync_q    <= 1'b0;
            divisor_q     <= 4'd0;
            shadow_q      <= 4'd0;
            div_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            burst_done_q  <= 1'b0;
            ticks_left_q  <= '0;
            done_lock_q   <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!bus.pit_en)
                        done_lock_q <= 1'b0;
                    if (bus.pit_en && !done_lock_q) begin
                        state_q      <= ST_RUN;
                        cnt_sync_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        ticks_left_q <= bus.burst_len;
                    end
                    if (bus.div_wr)
                        divisor_q <= wv;
                end
                default: begin
                    if (tick && ticks_left_q != '0)
                        ticks_left_q <= ticks_left_q - BURST_SIZE'(1);

                    if (to_idle) begin
                        state_q    <= ST_IDLE;
                        cnt_sync_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (burst_end) begin
                            burst_done_q <= 1'b1;
                            done_lock_q  <= 1'b1;
                        end
                    end else if (state_q == ST_RUN && !bus.pit_en) begin
                        state_q <= ST_STOP;
                    end else if (state_q == ST_STOP && bus.pit_en) begin
                        state_q <= ST_RUN;
                    end

                    if (bus.div_wr && (tick || to_idle)) begin
                        divisor_q     <= wv;
                        shadow_q      <= wv;
                        div_pending_q <= 1'b0;
                    end else if (bus.div_wr) begin
                        shadow_q      <= wv;
                        div_pending_q <= 1'b1;
                    end else if (div_pending_q && (tick || to_idle)) begin
                        divisor_q     <= shadow_q;
                        div_pending_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.cnt_sync_o  = cnt_sync_q;
    assign bus.divisor_o   = divisor_q;
    assign bus.div_pending = div_pending_q;
    assign bus.busy        = busy_q;
    assign bus.burst_done  = burst_done_q;
    assign bus.ticks_left  = ticks_left_q;
endmodule

// File: tb/tb_pit_prescale_ctrl.sv
// Bench for pit_prescale_ctrl: directed plan steps then random traffic, two DUTs (decade / binary map)
// compared every cycle against a cycle-level reference model.
module tb_pit_prescale_ctrl;
    localparam int BS = 16;

    logic          bus_clk = 1'b0;
    logic          async_rst_b;
    logic          sync_reset;
    logic          pit_en, grace_stop, div_wr, prescale_out;
    logic [3:0]    div_wdata;
    logic [BS-1:0] burst_len;

    int n_vec = 0;
    int n_err = 0;

    always #5 bus_clk = ~bus_clk;

    pit_prescale_ctrl_if #(.BURST_SIZE(BS)) bus0 ();
    pit_prescale_ctrl_if #(.BURST_SIZE(BS)) bus1 ();

    assign bus0.pit_en = pit_en;       assign bus1.pit_en = pit_en;
    assign bus0.grace_stop = grace_stop; assign bus1.grace_stop = grace_stop;
    assign bus0.div_wr = div_wr;       assign bus1.div_wr = div_wr;
    assign bus0.div_wdata = div_wdata; assign bus1.div_wdata = div_wdata;
    assign bus0.burst_len = burst_len; assign bus1.burst_len = burst_len;
    assign bus0.prescale_out = prescale_out; assign bus1.prescale_out = prescale_out;

    pit_prescale_ctrl #(.DECADE_CNTR(1), .BURST_SIZE(BS)) dut_dec (
        .bus_clk(bus_clk), .async_rst_b(async_rst_b), .sync_reset(sync_reset), .bus(bus0));
    pit_prescale_ctrl #(.DECADE_CNTR(0), .BURST_SIZE(BS)) dut_bin (
        .bus_clk(bus_clk), .async_rst_b(async_rst_b), .sync_reset(sync_reset), .bus(bus1));

    // mode: 0 idle, 1 running, 2 winding down after a graceful stop request
    typedef struct {
        int mode;
        int div;
        int shadow;
        bit pend;
        int left;
        bit lock;
        bit done;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_next(mdl_t m, bit dec);
        mdl_t n;
        int   wv;
        bit   tick, finish, apply;
        n      = m;
        n.done = 1'b0;
        if (sync_reset) begin
            n = '{0, 0, 0, 1'b0, 0, 1'b0, 1'b0};
            return n;
        end
        wv     = (dec && div_wdata > 8) ? 8 : int'(div_wdata);
        tick   = (m.mode != 0) && prescale_out;
        finish = tick && (m.left == 1);
        if (m.mode == 0) begin
            if (!pit_en) n.lock = 1'b0;
            if (pit_en && !m.lock) begin
                n.mode = 1;
                n.left = int'(burst_len);
            end
            if (div_wr) n.div = wv;
        end else begin
            if (tick && m.left > 0) n.left = m.left - 1;
            if (finish) begin
                n.mode = 0; n.done = 1'b1; n.lock = 1'b1;
            end else if (m.mode == 1 && !pit_en) begin
                n.mode = grace_stop ? 2 : 0;
            end else if (m.mode == 2) begin
                n.mode = pit_en ? 1 : (tick ? 0 : 2);
            end
            apply = tick || (n.mode == 0);
            if (div_wr && apply) begin
                n.div = wv; n.pend = 1'b0;
            end else if (div_wr) begin
                n.shadow = wv; n.pend = 1'b1;
            end else if (m.pend && apply) begin
                n.div = m.shadow; n.pend = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("dec.cnt_sync_o",  32'(bus0.cnt_sync_o),  32'(m0.mode != 0));
        chk("dec.busy",        32'(bus0.busy),        32'(m0.mode != 0));
        chk("dec.divisor_o",   32'(bus0.divisor_o),   32'(m0.div));
        chk("dec.div_pending", 32'(bus0.div_pending), 32'(m0.pend));
        chk("dec.burst_done",  32'(bus0.burst_done),  32'(m0.done));
        chk("dec.ticks_left",  32'(bus0.ticks_left),  32'(m0.left));
        chk("bin.cnt_sync_o",  32'(bus1.cnt_sync_o),  32'(m1.mode != 0));
        chk("bin.divisor_o",   32'(bus1.divisor_o),   32'(m1.div));
        chk("bin.div_pending", 32'(bus1.div_pending), 32'(m1.pend));
    endtask

    // Inputs are set by the caller after a falling edge; one clock is applied and all outputs checked.
    task automatic step();
        @(posedge bus_clk);
        m0 = mdl_next(m0, 1'b1);
        m1 = mdl_next(m1, 1'b0);
        @(negedge bus_clk);
        chk_all();
    endtask

    initial begin
        async_rst_b = 1'b0; sync_reset = 1'b0;
        pit_en = 1'b0; grace_stop = 1'b0; div_wr = 1'b0; div_wdata = 4'd0;
        burst_len = '0; prescale_out = 1'b0;
        m0 = '{0, 0, 0, 1'b0, 0, 1'b0, 1'b0};
        m1 = m0;
        repeat (2) @(negedge bus_clk);
        async_rst_b = 1'b1;
        chk_all();

        // continuous run starts one cycle after pit_en
        pit_en = 1'b1; burst_len = '0;
        step();
        chk("start.cnt_sync_o", 32'(bus0.cnt_sync_o), 32'd1);
        chk("start.ticks_left", 32'(bus0.ticks_left), 32'd0);

        // shadowed divisor write, applied on the tick seven cycles later
        div_wr = 1'b1; div_wdata = 4'd5;
        step();
        div_wr = 1'b0;
        repeat (6) step();
        chk("shadow.pending", 32'(bus0.div_pending), 32'd1);
        chk("shadow.held",    32'(bus0.divisor_o),   32'd0);
        prescale_out = 1'b1;
        step();
        prescale_out = 1'b0;
        chk("shadow.applied", 32'(bus0.divisor_o), 32'd5);

        // immediate stop, then clamp check in idle
        pit_en = 1'b0;
        step();
        div_wr = 1'b1; div_wdata = 4'd12;
        step();
        div_wr = 1'b0;
        chk("clamp.decade", 32'(bus0.divisor_o), 32'd8);
        chk("clamp.binary", 32'(bus1.divisor_o), 32'd12);

        // 3-tick burst with pit_en held, then rearm
        pit_en = 1'b1; burst_len = BS'(3);
        step();
        prescale_out = 1'b1;
        repeat (3) step();
        chk("burst.done", 32'(bus0.burst_done), 32'd1);
        prescale_out = 1'b0;
        repeat (3) step();
        chk("burst.no_restart", 32'(bus0.cnt_sync_o), 32'd0);
        pit_en = 1'b0;
        step();
        pit_en = 1'b1;
        step();
        chk("burst.rearm_left", 32'(bus0.ticks_left), 32'd3);

        // graceful stop completes on the next tick
        grace_stop = 1'b1; pit_en = 1'b0;
        step();
        step();
        chk("grace.still_on", 32'(bus0.cnt_sync_o), 32'd1);
        prescale_out = 1'b1;
        step();
        prescale_out = 1'b0;
        chk("grace.off", 32'(bus0.cnt_sync_o), 32'd0);

        // graceful stop cancelled before the tick
        pit_en = 1'b1;
        step();
        pit_en = 1'b0;
        step();
        pit_en = 1'b1;
        step();
        prescale_out = 1'b1;
        step();
        prescale_out = 1'b0;
        chk("grace.cancel_run", 32'(bus0.cnt_sync_o), 32'd1);

        // sync_reset with a pending divisor and ticks_left=2
        div_wr = 1'b1; div_wdata = 4'd3;
        step();
        div_wr = 1'b0;
        chk("srst.setup_left", 32'(bus0.ticks_left), 32'd2);
        sync_reset = 1'b1; prescale_out = 1'b1;
        step();
        sync_reset = 1'b0; prescale_out = 1'b0;
        chk("srst.busy", 32'(bus0.busy), 32'd0);
        chk("srst.done", 32'(bus0.burst_done), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11) == 0) pit_en = ~pit_en;
            grace_stop   = ($urandom_range(1) == 1);
            prescale_out = ($urandom_range(3) == 0);
            div_wr       = ($urandom_range(7) == 0);
            div_wdata    = 4'($urandom_range(15));
            burst_len    = BS'($urandom_range(4));
            sync_reset   = ($urandom_range(199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
